// File: rtl/powlib_sfifo_if.sv
// Producer/consumer handshake bundle for powlib_sfifo.
interface powlib_sfifo_if #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 8
);
  localparam int unsigned WCNT = $clog2(D + 1);

  logic [W-1:0]    wrdata;
  logic            wrvld;
  logic            wrrdy;
  logic [W-1:0]    rddata;
  logic            rdvld;
  logic            rdrdy;
  logic [WCNT-1:0] cnt;
  logic            afull;
  logic            aempty;

  // Side that pushes/pops words.
  modport master (
    output wrdata, wrvld, rdrdy,
    input  wrrdy, rddata, rdvld, cnt, afull, aempty
  );

  // The FIFO itself.
  modport slave (
    input  wrdata, wrvld, rdrdy,
    output wrrdy, rddata, rdvld, cnt, afull, aempty
  );
endinterface

// File: rtl/powlib_sfifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and
// almost-full / almost-empty flags. Depth need not be a power of two.
module powlib_sfifo #(
  parameter int unsigned W    = 32,
  parameter int unsigned D    = 8,
  parameter int unsigned WIDX = $clog2(D),
  parameter int unsigned WCNT = $clog2(D + 1),
  parameter int unsigned AFT  = D - 1,
  parameter int unsigned AET  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  powlib_sfifo_if.slave    bus
);

  localparam logic [WIDX-1:0] LAST_IDX = WIDX'(D - 1);
  localparam logic [WCNT-1:0] FULL_CNT = WCNT'(D);

  logic [W-1:0]    mem_q [D];
  logic [WIDX-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDX-1:0] rd_ptr_q, rd_ptr_d;
  logic [WCNT-1:0] cnt_q, cnt_d;
  logic            wrrdy_c;
  logic            rdvld_c;
  logic            wr_en_c;
  logic            rd_en_c;

  // Handshake qualification; a full FIFO refuses writes even when a read
  // frees a slot in the same cycle.
  always_comb begin
    wrrdy_c = (cnt_q != FULL_CNT);
    rdvld_c = (cnt_q != '0);
    wr_en_c = bus.wrvld && wrrdy_c;
    rd_en_c = bus.rdrdy && rdvld_c;
  end

  // Next pointers/count; flush overrides any transfer in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + WIDX'(1);
      end
      if (rd_en_c) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + WIDX'(1);
      end
      case ({wr_en_c, rd_en_c})
        2'b10:   cnt_d = cnt_q + WCNT'(1);
        2'b01:   cnt_d = cnt_q - WCNT'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_en_c && !clr) begin
      mem_q[wr_ptr_q] <= bus.wrdata;
    end
  end

  // Status and head-of-queue data, all derived from registered state.
  always_comb begin
    bus.wrrdy  = wrrdy_c;
    bus.rdvld  = rdvld_c;
    bus.rddata = mem_q[rd_ptr_q];
    bus.cnt    = cnt_q;
    bus.afull  = (cnt_q >= WCNT'(AFT));
    bus.aempty = (cnt_q <= WCNT'(AET));
  end

endmodule

// File: tb/tb_powlib_sfifo.sv
// Bench for powlib_sfifo: a depth-4 and a depth-5 instance share stimulus
// and are compared each cycle against queue-based reference models.
module tb_powlib_sfifo;

  localparam int unsigned W  = 8;
  localparam int unsigned DA = 4;
  localparam int unsigned DB = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  powlib_sfifo_if #(.W(W), .D(DA)) ifa ();
  powlib_sfifo_if #(.W(W), .D(DB)) ifb ();

  powlib_sfifo #(.W(W), .D(DA)) dut_a (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (ifa)
  );

  powlib_sfifo #(.W(W), .D(DB)) dut_b (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus to both FIFOs, return at the following negedge.
  task automatic drive(input logic wv, input logic [W-1:0] wd, input logic rr, input logic cl);
    ifa.wrvld  = wv;
    ifa.wrdata = wd;
    ifa.rdrdy  = rr;
    ifb.wrvld  = wv;
    ifb.wrdata = wd;
    ifb.rdrdy  = rr;
    clr        = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference queues: flush wins, full refuses writes, empty refuses reads.
  always @(posedge clk or posedge rst) begin : model
    bit wa, ra, wb, rb;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else if (clr) begin
      qa.delete();
      qb.delete();
    end else begin
      wa = ifa.wrvld && (qa.size() < DA);
      ra = ifa.rdrdy && (qa.size() > 0);
      wb = ifb.wrvld && (qb.size() < DB);
      rb = ifb.rdrdy && (qb.size() > 0);
      if (ra) void'(qa.pop_front());
      if (wa) qa.push_back(ifa.wrdata);
      if (rb) void'(qb.pop_front());
      if (wb) qb.push_back(ifb.wrdata);
    end
  end

  // Per-cycle comparison of every output against the models.
  always @(negedge clk) begin
    if (!rst) begin
      check("a_cnt",    32'(ifa.cnt),    32'(qa.size()));
      check("a_wrrdy",  32'(ifa.wrrdy),  32'(qa.size() != DA));
      check("a_rdvld",  32'(ifa.rdvld),  32'(qa.size() != 0));
      check("a_afull",  32'(ifa.afull),  32'(qa.size() >= DA - 1));
      check("a_aempty", 32'(ifa.aempty), 32'(qa.size() <= 1));
      if (qa.size() > 0) check("a_data", 32'(ifa.rddata), 32'(qa[0]));
      check("b_cnt",    32'(ifb.cnt),    32'(qb.size()));
      check("b_wrrdy",  32'(ifb.wrrdy),  32'(qb.size() != DB));
      check("b_rdvld",  32'(ifb.rdvld),  32'(qb.size() != 0));
      check("b_afull",  32'(ifb.afull),  32'(qb.size() >= DB - 1));
      check("b_aempty", 32'(ifb.aempty), 32'(qb.size() <= 1));
      if (qb.size() > 0) check("b_data", 32'(ifb.rddata), 32'(qb[0]));
      check("b_ptr_range", 32'((dut_b.wr_ptr_q < 3'(DB)) && (dut_b.rd_ptr_q < 3'(DB))), 32'd1);
    end
  end

  initial begin
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 8'h11;
    exp_seq[1] = 8'h22;
    exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h44;

    ifa.wrvld = 1'b0; ifa.wrdata = '0; ifa.rdrdy = 1'b0;
    ifb.wrvld = 1'b0; ifb.wrdata = '0; ifb.rdrdy = 1'b0;

    // Reset values while rst is held.
    #3;
    check("rst_rdvld",  32'(ifa.rdvld),  32'd0);
    check("rst_wrrdy",  32'(ifa.wrrdy),  32'd1);
    check("rst_cnt",    32'(ifa.cnt),    32'd0);
    check("rst_aempty", 32'(ifa.aempty), 32'd1);
    check("rst_afull",  32'(ifa.afull),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, fifth write dropped, drain in order.
    for (int i = 0; i < 4; i++) drive(1'b1, exp_seq[i], 1'b0, 1'b0);
    check("full_cnt",   32'(ifa.cnt),   32'd4);
    check("full_wrrdy", 32'(ifa.wrrdy), 32'd0);
    check("full_afull", 32'(ifa.afull), 32'd1);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    check("drop_cnt", 32'(ifa.cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(ifa.rddata), 32'(exp_seq[i]));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_rdvld", 32'(ifa.rdvld), 32'd0);
    check("b_holds_55", 32'(ifb.rddata), 32'h55);

    // Steady streaming at cnt=2 across pointer wraps.
    drive(1'b1, 8'hA0, 1'b0, 1'b0);
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
      check("stream_cnt", 32'(ifa.cnt), 32'd2);
    end
    check("stream_head", 32'(ifa.rddata), 32'hB8);

    // Full with simultaneous read: read happens, write blocked.
    drive(1'b1, 8'hC0, 1'b0, 1'b0);
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    check("full2_wrrdy", 32'(ifa.wrrdy), 32'd0);
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    check("full_rw_cnt", 32'(ifa.cnt), 32'd3);

    // Flush beats a concurrent write.
    drive(1'b1, 8'hAA, 1'b0, 1'b1);
    check("clr_cnt",   32'(ifa.cnt),   32'd0);
    check("clr_rdvld", 32'(ifa.rdvld), 32'd0);

    // Asynchronous reset between edges with data queued.
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(ifa.cnt), 32'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_rdvld", 32'(ifa.rdvld), 32'd0);
    check("arst_cnt",   32'(ifa.cnt),   32'd0);
    check("arst_wrrdy", 32'(ifa.wrrdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset release accepts a write.
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_rst_cnt",  32'(ifa.cnt),    32'd1);
    check("post_rst_data", 32'(ifa.rddata), 32'h5A);

    // Randomised traffic: producer-heavy phase, then consumer-heavy phase.
    for (int i = 0; i < 400; i++) begin
      logic wv, rr, cl;
      if (i < 200) begin
        wv = ($urandom_range(0, 9) < 7);
        rr = ($urandom_range(0, 9) < 4);
      end else begin
        wv = ($urandom_range(0, 9) < 4);
        rr = ($urandom_range(0, 9) < 7);
      end
      cl = ($urandom_range(0, 99) == 0);
      drive(wv, 8'($urandom), rr, cl);
    end

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/powlib_sfifo.md
POWLIB_SFIFO -- requirements
Module: powlib_sfifo

Interface
REQ-001 Parameter: W, 32, data width in bits (>=1).
REQ-002 Parameter: D, 8, depth in words (>=2; need not be a power of two).
REQ-003 Parameter: WIDX, clogb2(D), read/write pointer width.
REQ-004 Parameter: WCNT, clogb2(D+1), occupancy count width.
REQ-005 Parameter: AFT, D-1, almost-full threshold (0..D).
REQ-006 Parameter: AET, 1, almost-empty threshold (0..D).
REQ-007 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-008 Port: rst  in  1  reset, asynchronous, active-high.
REQ-009 Port: clr  in  1  synchronous flush.
REQ-010 Port: wrdata  in  W  write data.
REQ-011 Port: wrvld  in  1  write request.
REQ-012 Port: wrrdy  out  1  space available; a write occurs when wrvld && wrrdy.
REQ-013 Port: rddata  out  W  head-of-queue data, meaningful only while rdvld=1.
REQ-014 Port: rdvld  out  1  queue non-empty.
REQ-015 Port: rdrdy  in  1  consumer accept; a read occurs when rdvld && rdrdy.
REQ-016 Port: cnt  out  WCNT  current occupancy, 0..D.
REQ-017 Port: afull  out  1  cnt >= AFT.
REQ-018 Port: aempty  out  1  cnt <= AET.

Function
REQ-019 Storage SHALL be a D-entry W-bit array with a registered write and a combinational (first-word-fall-through) read at the read pointer.
REQ-020 State SHALL consist of a write pointer, a read pointer (both WIDX) and cnt (WCNT), all registered.
REQ-021 wrrdy SHALL be (cnt != D), rdvld SHALL be (cnt != 0), and afull/aempty SHALL be combinational from the registered cnt.
REQ-022 On a write, wrdata SHALL be stored at the write pointer and the write pointer SHALL advance by 1, wrapping from D-1 to 0.
REQ-023 On a read, the read pointer SHALL advance by 1, wrapping from D-1 to 0; rddata SHALL show the next entry in the same cycle the pointer updates.
REQ-024 cnt SHALL increment on a write-only cycle, decrement on a read-only cycle, and hold when both or neither occur.
REQ-025 Latency: a word written into an empty FIFO at edge N SHALL appear with rdvld=1 immediately after edge N (one-cycle write-to-read latency); there is no same-cycle bypass.
REQ-026 Full: wrrdy=0 even if a read occurs in the same cycle; wrvld is ignored and no state changes from it.
REQ-027 Empty: a read cannot occur since rdvld=0; rdrdy is ignored.
REQ-028 Simultaneous read and write at 0<cnt<D SHALL both take effect and leave cnt unchanged.
REQ-029 clr=1 SHALL, at the next edge, reset both pointers and cnt to 0 and SHALL take priority over any write or read in that cycle; memory contents are not cleared.
REQ-030 Data order SHALL be strictly first-in first-out with no loss or duplication across any number of pointer wraps.

Reset
REQ-031 While rst=1, and independent of clk, the pointers and cnt SHALL be 0, giving rdvld=0, wrrdy=1, aempty=(0<=AET), afull=(AFT==0).
REQ-032 Assertion of rst mid-operation SHALL discard all queued words; memory contents need not be reset.
REQ-033 The first write SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 W=8,D=4: write 0x11,0x22,0x33,0x44 with rdrdy=0 -> cnt=4, wrrdy=0, afull=1; fifth write 0x55 dropped; then read 4 -> 0x11,0x22,0x33,0x44, rdvld=0.
REQ-035 D=4 at cnt=2: hold wrvld=rdrdy=1 for 10 cycles with incrementing data -> cnt stays 2, output order intact, pointers wrap twice.
REQ-036 D=4 at cnt=4: assert wrvld and rdrdy together -> read occurs, write is blocked, cnt=3 next cycle.
REQ-037 D=5 (non-power-of-two): stream 20 words with random rdrdy -> all 20 received in order; pointers never exceed 4.
REQ-038 At cnt=3: assert clr with wrvld=1 -> next cycle cnt=0, rdvld=0; then assert rst asynchronously between edges at cnt=2 -> rdvld drops before the next edge.
